spi_multilane_shift_register: RTL and testbench
===============================================

# spi_multilane_shift_register

Parametrised next-generation data path for the SPI master core. It widens the character buffer, adds dual and quad I/O lanes, and latches its configuration per transfer. It sits between the Wishbone register file (parallel load/read of the data register) and the clock generator, which supplies the `cpol_0`/`cpol_1` edge strobes. It serialises a word onto 1, 2 or 4 lanes and deserialises received lanes back into the same register.

## Interface
- `MAX_CHAR`, 128: data register width in bits.
  - Must be a multiple of 32 and ≥ 32.
- `CHAR_LEN_BITS`, 7: width of `len`; equals log2(`MAX_CHAR`).
- `NWORDS`, 4: number of 32-bit load words; equals `MAX_CHAR`/32.

Ports:
- `wb_clk_in` in 1: system clock. All logic runs on its rising edge.
- `wb_rst` in 1: reset, **synchronous and active-high**.
- `go` in 1: start request; sampled only in IDLE.
- `len` in `CHAR_LEN_BITS`: transfer length in bits; 0 means `MAX_CHAR`.
- `lsb` in 1: 1 = LSB-first, 0 = MSB-first.
- `mode` in 2: lane mode.
  - 00 = single; 01 = dual; 10 = quad.
  - 11 is treated as single.
- `dir` in 1: dual/quad direction; 0 = transmit, 1 = receive. Ignored in single mode.
- `tx_negedge` in 1: 1 = drive on `cpol_1` (falling sclk strobe), 0 = drive on `cpol_0`.
- `rx_negedge` in 1: 1 = sample on `cpol_1`, 0 = sample on `cpol_0`.
- `cpol_0` in 1: one-cycle strobe marking a rising sclk edge.
- `cpol_1` in 1: one-cycle strobe marking a falling sclk edge.
- `latch` in `NWORDS`: word select for a parallel load.
- `byte_sel` in 4: byte enables within the selected word.
- `p_in` in 32: parallel load data.
- `io_in` in 4: serial lane inputs.
  - In single mode, MISO is `io_in[1]`.
- `p_out` out `MAX_CHAR`: data register contents.
- `io_out` out 4: serial lane outputs.
  - In single mode, MOSI is `io_out[0]`.
- `io_oe` out 4: lane output enables.
- `tip` out 1: transfer in progress.
- `last` out 1: final group has been driven.
- `done` out 1: one-cycle pulse at transfer completion.

## Operation
- States:
  - IDLE: `tip`=0.
  - ACTIVE: `tip`=1.
- Lane width and length:
  - k = 1, 2 or 4 for single, dual and quad.
  - L = `len`, or `MAX_CHAR` when `len`=0.
  - Group count E = ceil(L/k). Groups beyond bit L-1 carry/receive whatever register bits occupy those positions (wrap not permitted; positions clipped to register).
- IDLE → ACTIVE on `go`=1:
  - Set cnt ← E and tx pointer ← 0.
  - Capture `len`, `lsb`, `mode`, `dir`, `tx_negedge` and `rx_negedge` into shadow registers.
  - Changes to these inputs during ACTIVE have no effect.
- Group j bit positions:
  - MSB-first: bits [L-1-j·k -: k].
  - LSB-first: bits [j·k +: k].
  - The highest-indexed lane carries the highest-numbered bit.
- Tx strobe (selected `cpol_x`, ACTIVE, cnt>0):
  - `io_out[k-1:0]` ← group (E-cnt).
  - cnt ← cnt-1.
  - `last`=1 once cnt reaches 0.
- Rx strobe (selected `cpol_x`, ACTIVE, at least one tx strobe since go):
  - Write the lane inputs into the positions of the most recently driven group.
  - Single mode uses `io_in[1]`; dual/quad use `io_in[k-1:0]`.
  - In dual/quad with `dir`=0, no data is written, but the strobe still counts for termination.
- Termination:
  - An rx strobe while cnt=0 moves to IDLE: `tip`←0, `last`←0, `done`←1 for one cycle.
  - Rx strobes before the first tx strobe are ignored.
- Output enables during ACTIVE:
  - Single: `io_oe`=4'b0001.
  - Dual, `dir`=0: 4'b0011.
  - Quad, `dir`=0: 4'b1111.
  - Any `dir`=1: 4'b0000.
- Output enables and data in IDLE:
  - `io_oe`=0.
  - `io_out` holds its last driven value.
- Parallel load (IDLE only): for each i with `latch[i]`=1, bytes of word i enabled by `byte_sel` ← `p_in`. Loads during ACTIVE are ignored.
- `go` during ACTIVE is ignored.
- Reset (any state) forces IDLE.
  - Clears `p_out`, `io_out`, `io_oe`, `tip`, `last`, `done`, cnt and all shadow config.
  - No `done` pulse is produced.

## Timing
- `go` is sampled at edge n; `tip`=1 and `io_oe` are valid after edge n. Strobes present in cycle n are ignored.
- Each strobe takes effect at the clock edge on which it is high.
  - `io_out` updates the cycle after the tx strobe.
  - Sampled data appears on `p_out` the cycle after the rx strobe.
- If a tx and an rx strobe coincide, the rx write uses the group driven before this cycle's tx; both operations happen.
- `done` is high exactly one cycle, coincident with `tip` falling. A new `go` is accepted in the cycle after `tip` falls.
- Parallel load is visible on `p_out` one cycle after `latch`.

## Test plan
- Single mode, word0=0x000000A5, `len`=8, `lsb`=0, `tx_negedge`=1, `rx_negedge`=0, MISO bits 0,0,1,1,1,1,0,0 → `io_out[0]` sequence 1,0,1,0,0,1,0,1; `p_out[7:0]`=0x3C; 8 tx strobes; one `done` pulse; `tip` low afterwards.
- Quad transmit, word0=0x00001234, `len`=16, `lsb`=1, `dir`=0 → `io_out` nibbles 4,3,2,1; `io_oe`=4'hF during `tip`; `last` asserted after the 4th tx strobe.
- Dual receive, `len`=8, `lsb`=0, `dir`=1, `io_in[1:0]` = 11,00,10,01 → `p_out[7:0]`=0xC9; `io_oe`=0 throughout.
- `len`=0, single mode → 128 tx strobes before `last`; `done` follows the next rx strobe; `len`/`mode` toggled mid-transfer has no effect.
- IDLE load `latch`=4'b0010, `byte_sel`=4'b0101, `p_in`=0xAABBCCDD → `p_out[63:32]`=0x00BB00DD; the same load during `tip` leaves `p_out` unchanged; `go` during `tip` is ignored.
- `wb_rst` after 3 tx strobes → next cycle `tip`=0, `p_out`=0, `io_oe`=0, `io_out`=0; no `done` pulse.

Source files
------------

// File: rtl/spi_multilane_shift_register.sv
// Multi-lane SPI data register: parallel load/read from the bus side,
// serialisation onto 1, 2 or 4 lanes and deserialisation back into the
// same register. Configuration is captured once per transfer on go.
module spi_multilane_shift_register #(
    parameter int MAX_CHAR      = 128,
    parameter int CHAR_LEN_BITS = 7,
    parameter int NWORDS        = 4
) (
    input  logic                     wb_clk_in,
    input  logic                     wb_rst,
    input  logic                     go,
    input  logic [CHAR_LEN_BITS-1:0] len,
    input  logic                     lsb,
    input  logic [1:0]               mode,
    input  logic                     dir,
    input  logic                     tx_negedge,
    input  logic                     rx_negedge,
    input  logic                     cpol_0,
    input  logic                     cpol_1,
    input  logic [NWORDS-1:0]        latch,
    input  logic [3:0]               byte_sel,
    input  logic [31:0]              p_in,
    input  logic [3:0]               io_in,
    output logic [MAX_CHAR-1:0]      p_out,
    output logic [3:0]               io_out,
    output logic [3:0]               io_oe,
    output logic                     tip,
    output logic                     last,
    output logic                     done
);

    // CW holds counts up to MAX_CHAR; PW is a signed width wide enough for
    // bit positions that may fall below zero or past the register end.
    localparam int CW = CHAR_LEN_BITS + 1;
    localparam int PW = CHAR_LEN_BITS + 5;
    localparam logic signed [PW-1:0] MAX_POS = PW'(MAX_CHAR);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state;
    state_t                 state_next;

    logic [MAX_CHAR-1:0]    data;
    logic [CW-1:0]          s_len;
    logic                   s_lsb;
    logic [1:0]             s_mode;
    logic                   s_dir;
    logic                   s_tx_neg;
    logic                   s_rx_neg;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          tx_ptr;
    logic [CW-1:0]          drv_grp;
    logic                   have_tx;

    logic [2:0]             s_k;
    logic [CW-1:0]          go_len;
    logic [CW-1:0]          go_groups;
    logic                   tx_stb;
    logic                   rx_stb;
    logic                   finish;
    logic                   rx_we;
    logic signed [PW-1:0]   tx_pos [4];
    logic signed [PW-1:0]   rx_pos [4];
    logic [3:0]             tx_ok;
    logic [3:0]             rx_ok;
    logic [3:0]             tx_bits;
    logic [3:0]             rx_src;

    // Lanes per group: 11 falls back to single.
    function automatic logic [2:0] lane_width(input logic [1:0] m);
        case (m)
            2'b01:   lane_width = 3'd2;
            2'b10:   lane_width = 3'd4;
            default: lane_width = 3'd1;
        endcase
    endfunction

    // ceil(L/k) without overflowing the CW-bit count.
    function automatic logic [CW-1:0] group_count(input logic [CW-1:0] l, input logic [1:0] m);
        logic [CW:0] ext;
        ext = {1'b0, l};
        case (m)
            2'b01:   group_count = CW'((ext + (CW+1)'(1)) >> 1);
            2'b10:   group_count = CW'((ext + (CW+1)'(3)) >> 2);
            default: group_count = l;
        endcase
    endfunction

    // Register bit carried by one lane of one group; the highest lane
    // always carries the highest-numbered bit of the group.
    function automatic logic signed [PW-1:0] lane_pos(input logic [CW-1:0] l, input logic [CW-1:0] grp,
                                                       input logic [2:0] k, input logic lsb_first,
                                                       input logic [1:0] lane);
        logic signed [PW-1:0] sl;
        logic signed [PW-1:0] sk;
        logic signed [PW-1:0] sn;
        logic signed [PW-1:0] base;
        sl   = $signed(PW'(l));
        sk   = $signed(PW'(k));
        sn   = $signed(PW'(lane));
        base = $signed(PW'(grp)) * sk;
        if (lsb_first) lane_pos = base + sn;
        else           lane_pos = sl - base - sk + sn;
    endfunction

    // Positions outside the register are clipped rather than wrapped.
    function automatic logic in_range(input logic signed [PW-1:0] pos);
        in_range = !pos[PW-1] && (pos < MAX_POS);
    endfunction

    assign s_k       = lane_width(s_mode);
    assign go_len    = (len == '0) ? CW'(MAX_CHAR) : CW'(len);
    assign go_groups = group_count(go_len, mode);
    assign tx_stb    = (state == ACTIVE) && (s_tx_neg ? cpol_1 : cpol_0) && (cnt != '0);
    assign rx_stb    = (state == ACTIVE) && (s_rx_neg ? cpol_1 : cpol_0) && have_tx;
    assign finish    = rx_stb && (cnt == '0);
    assign rx_we     = (s_k == 3'd1) || s_dir;
    assign p_out     = data;

    // Per-lane bit positions for the next group to drive and the group last driven.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            tx_pos[i]  = lane_pos(s_len, tx_ptr, s_k, s_lsb, 2'(i));
            rx_pos[i]  = lane_pos(s_len, drv_grp, s_k, s_lsb, 2'(i));
            tx_ok[i]   = in_range(tx_pos[i]) && (3'(i) < s_k);
            rx_ok[i]   = in_range(rx_pos[i]) && (3'(i) < s_k);
            tx_bits[i] = tx_ok[i] ? data[tx_pos[i][CHAR_LEN_BITS-1:0]] : 1'b0;
            rx_src[i]  = (s_k == 3'd1) ? io_in[1] : io_in[i];
        end
    end

    // State register.
    always_ff @(posedge wb_clk_in) begin
        if (wb_rst) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state decode plus tip and lane output enables.
    always_comb begin
        state_next = state;
        tip        = 1'b0;
        io_oe      = 4'b0000;
        case (state)
            IDLE: begin
                if (go) state_next = ACTIVE;
            end
            ACTIVE: begin
                tip = 1'b1;
                if (s_k == 3'd1)      io_oe = 4'b0001;
                else if (!s_dir)      io_oe = (s_k == 3'd2) ? 4'b0011 : 4'b1111;
                if (finish) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Config capture, group counters, lane drive, sampling and parallel load.
    always_ff @(posedge wb_clk_in) begin
        if (wb_rst) begin
            data     <= '0;
            s_len    <= '0;
            s_lsb    <= 1'b0;
            s_mode   <= 2'b00;
            s_dir    <= 1'b0;
            s_tx_neg <= 1'b0;
            s_rx_neg <= 1'b0;
            cnt      <= '0;
            tx_ptr   <= '0;
            drv_grp  <= '0;
            have_tx  <= 1'b0;
            io_out   <= 4'b0000;
            last     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (go) begin
                    s_len    <= go_len;
                    s_lsb    <= lsb;
                    s_mode   <= mode;
                    s_dir    <= dir;
                    s_tx_neg <= tx_negedge;
                    s_rx_neg <= rx_negedge;
                    cnt      <= go_groups;
                    tx_ptr   <= '0;
                    have_tx  <= 1'b0;
                    last     <= 1'b0;
                end
                for (int w = 0; w < NWORDS; w++) begin
                    for (int b = 0; b < 4; b++) begin
                        if (latch[w] && byte_sel[b]) data[w*32 + b*8 +: 8] <= p_in[b*8 +: 8];
                    end
                end
            end else begin
                if (tx_stb) begin
                    for (int i = 0; i < 4; i++) begin
                        if (3'(i) < s_k) io_out[i] <= tx_bits[i];
                    end
                    drv_grp <= tx_ptr;
                    tx_ptr  <= tx_ptr + CW'(1);
                    cnt     <= cnt - CW'(1);
                    have_tx <= 1'b1;
                    if (cnt == CW'(1)) last <= 1'b1;
                end
                // The rx write uses drv_grp as registered before this edge, so a
                // coincident tx strobe does not disturb which group is sampled.
                if (rx_stb) begin
                    if (rx_we) begin
                        for (int i = 0; i < 4; i++) begin
                            if (rx_ok[i]) data[rx_pos[i][CHAR_LEN_BITS-1:0]] <= rx_src[i];
                        end
                    end
                    if (cnt == '0) begin
                        last <= 1'b0;
                        done <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_multilane_shift_register.sv
// Directed bench for spi_multilane_shift_register: single, quad and dual
// transfers, full-length transfer, load/go gating while busy, and reset.
module tb_spi_multilane_shift_register;

    logic         wb_clk_in;
    logic         wb_rst;
    logic         go;
    logic [6:0]   len;
    logic         lsb;
    logic [1:0]   mode;
    logic         dir;
    logic         tx_negedge;
    logic         rx_negedge;
    logic         cpol_0;
    logic         cpol_1;
    logic [3:0]   latch;
    logic [3:0]   byte_sel;
    logic [31:0]  p_in;
    logic [3:0]   io_in;
    logic [127:0] p_out;
    logic [3:0]   io_out;
    logic [3:0]   io_oe;
    logic         tip;
    logic         last;
    logic         done;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [7:0]   exp_tx;
    logic [7:0]   miso;
    logic [15:0]  exp_q;
    logic [7:0]   din;
    logic [127:0] snap;

    spi_multilane_shift_register #(
        .MAX_CHAR(128),
        .CHAR_LEN_BITS(7),
        .NWORDS(4)
    ) dut (
        .wb_clk_in (wb_clk_in),
        .wb_rst    (wb_rst),
        .go        (go),
        .len       (len),
        .lsb       (lsb),
        .mode      (mode),
        .dir       (dir),
        .tx_negedge(tx_negedge),
        .rx_negedge(rx_negedge),
        .cpol_0    (cpol_0),
        .cpol_1    (cpol_1),
        .latch     (latch),
        .byte_sel  (byte_sel),
        .p_in      (p_in),
        .io_in     (io_in),
        .p_out     (p_out),
        .io_out    (io_out),
        .io_oe     (io_oe),
        .tip       (tip),
        .last      (last),
        .done      (done)
    );

    initial wb_clk_in = 1'b0;
    always #5 wb_clk_in = ~wb_clk_in;

    task automatic step();
        @(posedge wb_clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-cycle strobe on cpol_1 (fall=1) or cpol_0 (fall=0).
    task automatic strobe(input logic fall);
        if (fall) cpol_1 = 1'b1;
        else      cpol_0 = 1'b1;
        step();
        cpol_0 = 1'b0;
        cpol_1 = 1'b0;
    endtask

    task automatic load(input logic [3:0] w, input logic [3:0] be, input logic [31:0] d);
        latch = w; byte_sel = be; p_in = d;
        step();
        latch = 4'b0000;
    endtask

    task automatic start(input logic [6:0] l, input logic lf, input logic [1:0] m,
                         input logic d, input logic txn, input logic rxn);
        len = l; lsb = lf; mode = m; dir = d; tx_negedge = txn; rx_negedge = rxn;
        go = 1'b1;
        step();
        go = 1'b0;
    endtask

    initial begin
        wb_rst = 1'b1; go = 1'b0; len = '0; lsb = 1'b0; mode = 2'b00; dir = 1'b0;
        tx_negedge = 1'b0; rx_negedge = 1'b0; cpol_0 = 1'b0; cpol_1 = 1'b0;
        latch = '0; byte_sel = '0; p_in = '0; io_in = '0;
        step();
        step();
        chk("rst_tip", tip, 1'b0);
        chk("rst_pout", p_out, 128'h0);
        chk("rst_ioout", io_out, 4'h0);
        chk("rst_oe", io_oe, 4'h0);
        chk("rst_done", done, 1'b0);
        chk("rst_last", last, 1'b0);
        wb_rst = 1'b0;
        step();

        // Single mode, MSB-first, drive on cpol_1, sample MISO on cpol_0.
        load(4'b0001, 4'hF, 32'h0000_00A5);
        chk("single_load", p_out, 128'hA5);
        start(7'd8, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        chk("single_tip", tip, 1'b1);
        chk("single_oe", io_oe, 4'b0001);
        exp_tx = 8'hA5;
        miso   = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            strobe(1'b1);
            chk($sformatf("single_tx%0d", i), io_out[0], exp_tx[7-i]);
            chk($sformatf("single_last%0d", i), last, (i == 7));
            io_in = {2'b00, miso[7-i], 1'b0};
            strobe(1'b0);
            chk($sformatf("single_done%0d", i), done, (i == 7));
            chk($sformatf("single_tipr%0d", i), tip, (i != 7));
        end
        step();
        chk("single_done_pulse", done, 1'b0);
        chk("single_hold_io", io_out, 4'b0001);
        chk("single_idle_oe", io_oe, 4'b0000);
        chk("single_pout", p_out, 128'h3C);

        // Quad transmit, LSB-first, drive on cpol_0, rx on cpol_1.
        load(4'b0001, 4'hF, 32'h0000_1234);
        io_in = 4'hF;
        start(7'd16, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
        chk("quad_oe", io_oe, 4'hF);
        exp_q = 16'h1234;
        for (int i = 0; i < 4; i++) begin
            strobe(1'b0);
            chk($sformatf("quad_tx%0d", i), io_out, exp_q[4*i +: 4]);
            chk($sformatf("quad_last%0d", i), last, (i == 3));
            chk($sformatf("quad_oe%0d", i), io_oe, 4'hF);
            strobe(1'b1);
            chk($sformatf("quad_done%0d", i), done, (i == 3));
        end
        chk("quad_pout", p_out, 128'h1234);
        chk("quad_tip", tip, 1'b0);

        // Dual receive, MSB-first.
        start(7'd8, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0);
        chk("dual_tip", tip, 1'b1);
        chk("dual_oe", io_oe, 4'b0000);
        din = 8'hC9;
        for (int i = 0; i < 4; i++) begin
            strobe(1'b1);
            io_in = {2'b00, din[7-2*i -: 2]};
            chk($sformatf("dual_oe%0d", i), io_oe, 4'b0000);
            strobe(1'b0);
            chk($sformatf("dual_done%0d", i), done, (i == 3));
        end
        chk("dual_pout", p_out, 128'h12C9);

        // len=0: full 128-bit single transfer; config toggled mid-way.
        start(7'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        chk("full_tip", tip, 1'b1);
        for (int i = 0; i < 128; i++) begin
            strobe(1'b1);
            if (i == 5) begin
                len = 7'd3; mode = 2'b10; lsb = 1'b1; dir = 1'b1;
                tx_negedge = 1'b0; rx_negedge = 1'b1;
            end
            if (i >= 126) chk($sformatf("full_last%0d", i), last, (i == 127));
            io_in = {2'b00, i[0], 1'b0};
            strobe(1'b0);
            if (i == 5) chk("full_oe_after_toggle", io_oe, 4'b0001);
            if (i >= 126) chk($sformatf("full_done%0d", i), done, (i == 127));
        end
        chk("full_pout", p_out, {4{32'h5555_5555}});
        chk("full_tip_end", tip, 1'b0);

        // Byte-enabled load, then load and go while busy, then reset mid-transfer.
        wb_rst = 1'b1;
        step();
        wb_rst = 1'b0;
        chk("rst2_pout", p_out, 128'h0);
        load(4'b0001, 4'hF, 32'h0000_00A5);
        load(4'b0010, 4'b0101, 32'hAABB_CCDD);
        chk("load_word1", p_out[63:32], 32'h00BB_00DD);
        chk("load_full", p_out, {64'h0, 32'h00BB_00DD, 32'h0000_00A5});
        start(7'd8, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            strobe(1'b1);
            chk($sformatf("busy_tx%0d", i), io_out[0], exp_tx[7-i]);
        end
        snap = {64'h0, 32'h00BB_00DD, 32'h0000_00A5};
        load(4'b0010, 4'hF, 32'hFFFF_FFFF);
        chk("busy_load_ignored", p_out, snap);
        go = 1'b1;
        step();
        go = 1'b0;
        chk("busy_go_tip", tip, 1'b1);
        for (int i = 3; i < 6; i++) begin
            strobe(1'b1);
            chk($sformatf("busy_tx%0d", i), io_out[0], exp_tx[7-i]);
        end
        chk("busy_last", last, 1'b0);
        wb_rst = 1'b1;
        step();
        chk("rst3_tip", tip, 1'b0);
        chk("rst3_pout", p_out, 128'h0);
        chk("rst3_oe", io_oe, 4'h0);
        chk("rst3_ioout", io_out, 4'h0);
        chk("rst3_done", done, 1'b0);
        chk("rst3_last", last, 1'b0);
        wb_rst = 1'b0;
        step();
        chk("rst3_done_after", done, 1'b0);
        chk("rst3_tip_after", tip, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
